// File: rtl/nn_mem_loader.sv
// nn_mem_loader
//   Streams words from a valid/ready source into the mnist_nn load ports.
//   The words fill the weight banks 0..NUM_W_BANKS-1 in order, then the input
//   (X) bank. Once loading is complete, the loader hands the memories to the
//   compute engine and holds en_compute high until compute_finish.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle run request (only honoured in IDLE)
//   cfg_w_len         per-bank weight word counts, bank k at [k*W_ADDR_LEN +: W_ADDR_LEN]
//   cfg_x_len/x_sel   input word count and input bank select
//   cfg_skip_w        load the input bank only
//   in_valid/ready    stream handshake, in_data = stream word
//   w_*_oc / x_*_oc   weight / input write port (strobe, address, select)
//   wx_write_oc       write data shared by both ports
//   load_compute_ctrl 1 = load port owns the memories, 0 = compute owns them
//   en_compute        compute enable; compute_finish ends the run
//   busy, done        run in progress / end-of-run pulse
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_W  | writing weight banks, skipping zero-length banks
// LOAD_X  | writing the input bank
// HANDOFF | one cycle carrying the final write strobe, no new words
// COMPUTE | compute owns the memories until compute_finish

module nn_mem_loader #(
    parameter int W_ADDR_LEN  = 20,
    parameter int X_ADDR_LEN  = 10,
    parameter int W_SEL_LEN   = 2,
    parameter int X_SEL_LEN   = 2,
    parameter int DATA_LEN    = 1,
    parameter int NUM_W_BANKS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [NUM_W_BANKS*W_ADDR_LEN-1:0] cfg_w_len,
    input  logic [X_ADDR_LEN-1:0]             cfg_x_len,
    input  logic [X_SEL_LEN-1:0]              cfg_x_sel,
    input  logic                              cfg_skip_w,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_LEN-1:0]               in_data,
    output logic                              w_wq_oc,
    output logic [W_ADDR_LEN-1:0]             w_addr_oc,
    output logic [W_SEL_LEN-1:0]              w_sel_oc,
    output logic                              x_wq_oc,
    output logic [X_ADDR_LEN-1:0]             x_addr_oc,
    output logic [X_SEL_LEN-1:0]              x_sel_oc,
    output logic [DATA_LEN-1:0]               wx_write_oc,
    output logic                              load_compute_ctrl,
    output logic                              en_compute,
    input  logic                              compute_finish,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, HANDOFF, COMPUTE} state_t;

    localparam logic [W_ADDR_LEN-1:0] W_ONE = 1;
    localparam logic [X_ADDR_LEN-1:0] X_ONE = 1;

    state_t                  r_state;
    logic [W_ADDR_LEN-1:0]   r_w_len_a [NUM_W_BANKS];
    logic [NUM_W_BANKS-1:0]  r_nz;
    logic [X_ADDR_LEN-1:0]   r_x_len;
    logic [X_SEL_LEN-1:0]    r_x_sel;
    logic [W_SEL_LEN-1:0]    r_bank_idx;
    logic [W_ADDR_LEN-1:0]   r_w_cnt;
    logic [X_ADDR_LEN-1:0]   r_x_cnt;

    logic                    r_in_ready;
    logic                    r_w_wq;
    logic [W_ADDR_LEN-1:0]   r_w_addr;
    logic [W_SEL_LEN-1:0]    r_w_sel;
    logic                    r_x_wq;
    logic [X_ADDR_LEN-1:0]   r_x_addr;
    logic [X_SEL_LEN-1:0]    r_x_sel_o;
    logic [DATA_LEN-1:0]     r_wdata;
    logic                    r_lcc;
    logic                    r_en;
    logic                    r_busy;
    logic                    r_done;

    logic [NUM_W_BANKS-1:0]  w_cfg_nz;
    logic [W_SEL_LEN:0]      w_first;
    logic [W_SEL_LEN:0]      w_next;
    logic [W_ADDR_LEN-1:0]   w_cur_len;
    logic                    w_accept;

    // Lowest nonzero bank strictly above 'from'; MSB of result = found.
    function automatic logic [W_SEL_LEN:0] f_next_bank(input logic [NUM_W_BANKS-1:0] nz,
                                                       input int from);
        logic [W_SEL_LEN:0] res;
        res = '0;
        for (int k = NUM_W_BANKS - 1; k >= 0; k--) begin
            if (k > from && nz[k]) res = {1'b1, k[W_SEL_LEN-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        w_cfg_nz = '0;
        for (int k = 0; k < NUM_W_BANKS; k++)
            w_cfg_nz[k] = |cfg_w_len[k*W_ADDR_LEN +: W_ADDR_LEN];
    end

    assign w_first   = f_next_bank(w_cfg_nz, -1);
    assign w_next    = f_next_bank(r_nz, int'(r_bank_idx));
    assign w_cur_len = r_w_len_a[r_bank_idx];
    assign w_accept  = in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            for (int k = 0; k < NUM_W_BANKS; k++) r_w_len_a[k] <= '0;
            r_nz       <= '0;
            r_x_len    <= '0;
            r_x_sel    <= '0;
            r_bank_idx <= '0;
            r_w_cnt    <= '0;
            r_x_cnt    <= '0;
            r_in_ready <= 1'b0;
            r_w_wq     <= 1'b0;
            r_w_addr   <= '0;
            r_w_sel    <= '0;
            r_x_wq     <= 1'b0;
            r_x_addr   <= '0;
            r_x_sel_o  <= '0;
            r_wdata    <= '0;
            r_lcc      <= 1'b1;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_w_wq <= 1'b0;
            r_x_wq <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_W_BANKS; k++)
                            r_w_len_a[k] <= cfg_w_len[k*W_ADDR_LEN +: W_ADDR_LEN];
                        r_nz       <= w_cfg_nz;
                        r_x_len    <= cfg_x_len;
                        r_x_sel    <= cfg_x_sel;
                        r_w_cnt    <= '0;
                        r_x_cnt    <= '0;
                        r_bank_idx <= w_first[W_SEL_LEN-1:0];
                        r_busy     <= 1'b1;
                        if (!cfg_skip_w && w_first[W_SEL_LEN]) begin
                            r_state    <= LOAD_W;
                            r_in_ready <= 1'b1;
                        end else if (cfg_x_len != '0) begin
                            r_state    <= LOAD_X;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= HANDOFF;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_accept) begin
                        r_w_wq   <= 1'b1;
                        r_w_addr <= r_w_cnt;
                        r_w_sel  <= r_bank_idx;
                        r_wdata  <= in_data;
                        if (r_w_cnt == w_cur_len - W_ONE) begin
                            r_w_cnt <= '0;
                            if (w_next[W_SEL_LEN]) begin
                                r_bank_idx <= w_next[W_SEL_LEN-1:0];
                            end else if (r_x_len != '0) begin
                                r_state <= LOAD_X;
                            end else begin
                                r_state    <= HANDOFF;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_w_cnt <= r_w_cnt + W_ONE;
                        end
                    end
                end
                LOAD_X: begin
                    if (w_accept) begin
                        r_x_wq    <= 1'b1;
                        r_x_addr  <= r_x_cnt;
                        r_x_sel_o <= r_x_sel;
                        r_wdata   <= in_data;
                        if (r_x_cnt == r_x_len - X_ONE) begin
                            r_x_cnt    <= '0;
                            r_state    <= HANDOFF;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_x_cnt <= r_x_cnt + X_ONE;
                        end
                    end
                end
                HANDOFF: begin
                    r_state <= COMPUTE;
                    r_lcc   <= 1'b0;
                    r_en    <= 1'b1;
                end
                COMPUTE: begin
                    if (compute_finish) begin
                        r_state <= IDLE;
                        r_lcc   <= 1'b1;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready          = r_in_ready;
    assign w_wq_oc           = r_w_wq;
    assign w_addr_oc         = r_w_addr;
    assign w_sel_oc          = r_w_sel;
    assign x_wq_oc           = r_x_wq;
    assign x_addr_oc         = r_x_addr;
    assign x_sel_oc          = r_x_sel_o;
    assign wx_write_oc       = r_wdata;
    assign load_compute_ctrl = r_lcc;
    assign en_compute        = r_en;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule

// File: tb/tb_nn_mem_loader.sv
// Directed bench for nn_mem_loader: each run's write sequence is rebuilt from
// the run configuration and compared against the strobes seen on the ports.

module tb_nn_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [79:0] cfg_w_len = '0;
    logic [9:0]  cfg_x_len = '0;
    logic [1:0]  cfg_x_sel = '0;
    logic        cfg_skip_w = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:0]  in_data = '0;
    logic        w_wq_oc;
    logic [19:0] w_addr_oc;
    logic [1:0]  w_sel_oc;
    logic        x_wq_oc;
    logic [9:0]  x_addr_oc;
    logic [1:0]  x_sel_oc;
    logic [0:0]  wx_write_oc;
    logic        load_compute_ctrl;
    logic        en_compute;
    logic        compute_finish = 1'b0;
    logic        busy;
    logic        done;

    nn_mem_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_w_len(cfg_w_len), .cfg_x_len(cfg_x_len), .cfg_x_sel(cfg_x_sel),
        .cfg_skip_w(cfg_skip_w),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_wq_oc(w_wq_oc), .w_addr_oc(w_addr_oc), .w_sel_oc(w_sel_oc),
        .x_wq_oc(x_wq_oc), .x_addr_oc(x_addr_oc), .x_sel_oc(x_sel_oc),
        .wx_write_oc(wx_write_oc), .load_compute_ctrl(load_compute_ctrl),
        .en_compute(en_compute), .compute_finish(compute_finish),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        isx;
        logic [1:0]  sel;
        logic [19:0] addr;
        logic        d;
    } wr_t;

    wr_t got[$];
    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  n_both = 0;
    int  n_orphan = 0;
    logic acc_prev = 1'b0;

    // Strobe monitor: records every write and flags strobes that do not
    // follow an acceptance on the previous edge.
    always @(negedge clk) begin
        if (w_wq_oc && x_wq_oc) n_both++;
        if ((w_wq_oc | x_wq_oc) !== acc_prev) n_orphan++;
        acc_prev = in_valid & in_ready & ~rst;
        if (w_wq_oc)
            got.push_back('{isx: 1'b0, sel: w_sel_oc, addr: w_addr_oc, d: wx_write_oc[0]});
        else if (x_wq_oc)
            got.push_back('{isx: 1'b1, sel: x_sel_oc, addr: {10'b0, x_addr_oc}, d: wx_write_oc[0]});
    end

    function automatic logic dat(input int k);
        return k[0] ^ k[2] ^ k[3];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(32'(load_compute_ctrl), 1, {tag, "_lcc"});
        chk(32'({en_compute, in_ready, busy, done, w_wq_oc, x_wq_oc}), 0, {tag, "_ctrl"});
        chk(32'(w_addr_oc), 0, {tag, "_waddr"});
        chk(32'({w_sel_oc, x_sel_oc, x_addr_oc, wx_write_oc}), 0, {tag, "_xsel_data"});
    endtask

    task automatic cmp_writes(input string tag);
        chk(32'(got.size()), 32'(exp_q.size()), {tag, "_write_count"});
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk(32'(got[i]), 32'(exp_q[i]), $sformatf("%s_write_%0d", tag, i));
    endtask

    // Full run: start, stream every word, handoff, compute, done.
    task automatic do_run(input string tag,
                          input logic [19:0] l0, input logic [19:0] l1,
                          input logic [19:0] l2, input logic [19:0] l3,
                          input logic [9:0] xl, input logic [1:0] xs,
                          input bit skip, input bit toggle, input bit poke,
                          input bit early, input int hold);
        logic [19:0] lens[4];
        int k, t, total, nw, ndone;
        logic acc;
        bit poked;
        lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
        exp_q.delete();
        got.delete();
        k = 0;
        if (!skip)
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < int'(lens[b]); a++) begin
                    exp_q.push_back('{isx: 1'b0, sel: 2'(b), addr: 20'(a), d: dat(k)});
                    k++;
                end
        nw = k;
        for (int a = 0; a < int'(xl); a++) begin
            exp_q.push_back('{isx: 1'b1, sel: xs, addr: 20'(a), d: dat(k)});
            k++;
        end
        total = k;

        cfg_w_len = {l3, l2, l1, l0};
        cfg_x_len = xl;
        cfg_x_sel = xs;
        cfg_skip_w = skip;
        start = 1'b1;
        step();
        start = 1'b0;
        chk(32'(busy), 1, {tag, "_busy_after_start"});
        chk(32'(in_ready), 1, {tag, "_ready_after_start"});

        k = 0; t = 0; poked = 1'b0;
        while (k < total && t < 4000) begin
            in_valid = toggle ? (t % 2 == 0) : 1'b1;
            in_data = dat(k);
            if (poke && !poked && k == nw) begin
                start = 1'b1;
                cfg_w_len = {20'd1, 20'd1, 20'd1, 20'd1};
                poked = 1'b1;
            end
            acc = in_valid & in_ready;
            step();
            start = 1'b0;
            t++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk(32'(k), 32'(total), {tag, "_words_accepted"});

        chk(32'(in_ready), 0, {tag, "_ready_handoff"});
        chk(32'(w_wq_oc | x_wq_oc), 1, {tag, "_final_strobe"});
        chk(32'({en_compute, load_compute_ctrl}), 32'b01, {tag, "_handoff_en_lcc"});
        if (early) compute_finish = 1'b1;
        step();
        chk(32'({en_compute, load_compute_ctrl, busy}), 32'b101, {tag, "_compute_entry"});
        if (early) begin
            step();
            compute_finish = 1'b0;
            chk(32'({en_compute, done, load_compute_ctrl}), 32'b011, {tag, "_early_finish"});
            step();
            chk(32'(done), 0, {tag, "_done_single"});
        end else begin
            step();
            chk(32'(en_compute), 1, {tag, "_en_hold"});
            if (poke) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk(32'({en_compute, busy}), 32'b11, {tag, "_start_in_compute"});
            end
            compute_finish = 1'b1;
            ndone = 0;
            for (int i = 0; i < hold + 3; i++) begin
                if (i == hold) compute_finish = 1'b0;
                step();
                ndone += int'(done);
                if (i == 0)
                    chk(32'({en_compute, done, load_compute_ctrl, busy}), 32'b0110,
                        {tag, "_finish"});
            end
            chk(32'(ndone), 1, {tag, "_done_count"});
            chk(32'(busy), 0, {tag, "_idle_after"});
        end
        cmp_writes(tag);
    endtask

    initial begin
        logic acc;
        int k, t;

        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();
        chk_reset_vals("idle");

        do_run("cont",   20'd6, 20'd9, 20'd9, 20'd9, 10'd2, 2'd0, 0, 0, 0, 0, 1);
        do_run("toggle", 20'd6, 20'd9, 20'd9, 20'd9, 10'd2, 2'd0, 0, 1, 0, 0, 1);
        do_run("gaps",   20'd4, 20'd0, 20'd3, 20'd0, 10'd1, 2'd1, 0, 0, 0, 0, 1);
        do_run("skipw",  20'd6, 20'd9, 20'd9, 20'd9, 10'd5, 2'd2, 1, 0, 0, 1, 1);

        // Reset in the middle of bank 1, with a word being offered.
        exp_q.delete();
        got.delete();
        for (int i = 0; i < 9; i++)
            exp_q.push_back('{isx: 1'b0, sel: (i < 6) ? 2'd0 : 2'd1,
                              addr: 20'((i < 6) ? i : i - 6), d: dat(i)});
        cfg_w_len = {20'd9, 20'd9, 20'd9, 20'd6};
        cfg_x_len = 10'd2;
        cfg_x_sel = 2'd0;
        cfg_skip_w = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0; t = 0;
        while (k < 9 && t < 100) begin
            in_valid = 1'b1;
            in_data = dat(k);
            acc = in_valid & in_ready;
            step();
            t++;
            if (acc) k++;
        end
        chk(32'({w_wq_oc, w_sel_oc, w_addr_oc}), {1'b1, 2'd1, 20'd2}, "rst_pre_strobe");
        in_data = 1'b1;
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        step();
        chk_reset_vals("rst_after");
        cmp_writes("rst");

        do_run("restart", 20'd6, 20'd9, 20'd9, 20'd9, 10'd2, 2'd0, 0, 0, 0, 0, 1);
        do_run("poke",    20'd3, 20'd2, 20'd0, 20'd0, 10'd4, 2'd3, 0, 1, 1, 0, 3);

        // Nothing to load: straight to handoff.
        got.delete();
        cfg_w_len = '0;
        cfg_x_len = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk(32'({busy, in_ready, en_compute}), 32'b100, "empty_handoff");
        step();
        chk(32'({en_compute, load_compute_ctrl}), 32'b10, "empty_compute");
        compute_finish = 1'b1;
        step();
        compute_finish = 1'b0;
        chk(32'({done, busy, en_compute}), 32'b100, "empty_done");
        step();
        chk(32'(got.size()), 0, "empty_no_writes");

        chk(32'(n_both), 0, "both_strobes");
        chk(32'(n_orphan), 0, "strobe_without_accept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
